// File: rtl/clk_tick_pkg.sv
// clk_tick_pkg: shared widths, default constants and FSM states for clk_tick_monitor
package clk_tick_pkg;
  localparam int PERIOD_W = 17;
  localparam int MS_W = 10;
  localparam int NUM_DIV_DEF = 50000;
  localparam int TOL_DEF = 64;
  localparam int TIMEOUT_DEF = 100000;
  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED, LOST} state_e;
endpackage

// File: rtl/clk_tick_monitor_sync_edge_det.sv
// sync_edge_det: two-flop synchronizer plus edge flop; rise is combinational, tick is rise registered
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic tick
);
  logic [2:0] sh_q, sh_d;
  logic tick_q, tick_d;
  // shift s1 -> s2 -> s3 and flag s2 going high
  always_comb begin
    sh_d = {sh_q[1:0], d};
    rise = sh_q[1] & ~sh_q[2];
    tick_d = rise;
  end
  // synchronizer and tick registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q <= '0;
      tick_q <= 1'b0;
    end else begin
      sh_q <= sh_d;
      tick_q <= tick_d;
    end
  end
  assign tick = tick_q;
endmodule

// File: rtl/clk_tick_monitor.sv
// clk_tick_monitor: clk_div tick extraction, period lock/loss FSM and 1 s tick; CLK_TICK_MONITOR_JITTER_STATS_EN adds period min/max
module clk_tick_monitor
  import clk_tick_pkg::*;
#(
  parameter int NUM_DIV = NUM_DIV_DEF,
  parameter int TOL = TOL_DEF,
  parameter int LOCK_CNT = 4,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int MS_PER_SEC = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clk_div,
  output logic                tick,
  output logic                sec_tick,
  output logic                locked,
  output logic                lost,
  output logic [PERIOD_W-1:0] period,
  output logic [PERIOD_W-1:0] period_min,
  output logic [PERIOD_W-1:0] period_max
);
  localparam logic [PERIOD_W-1:0] LO = PERIOD_W'(NUM_DIV - TOL);
  localparam logic [PERIOD_W-1:0] HI = PERIOD_W'(NUM_DIV + TOL);
  localparam logic [PERIOD_W-1:0] TMO = PERIOD_W'(TIMEOUT);
  localparam logic [MS_W-1:0] MS_LAST = MS_W'(MS_PER_SEC - 1);
  localparam logic [7:0] LOCK_N = 8'(LOCK_CNT);
  state_e state_q, state_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d, period_q, period_d, period_new;
  logic [7:0] good_q, good_d;
  logic [MS_W-1:0] ms_q, ms_d;
  logic sec_q, sec_d;
  logic rise, good, measuring;
  sync_edge_det u_sync (
    .clk(clk),
    .rst(rst),
    .d(clk_div),
    .rise(rise),
    .tick(tick)
  );
  // period counter, lock FSM and ms divider; outputs land on the same edge as tick
  always_comb begin
    period_new = cnt_q + 1'b1;
    good = period_new >= LO && period_new <= HI;
    measuring = state_q == MEASURE || state_q == LOCKED;
    cnt_d = rise ? '0 : cnt_q == TMO ? cnt_q : cnt_q + 1'b1;
    period_d = rise && measuring ? period_new : period_q;
    state_d = state_q;
    good_d = good_q;
    if (rise && (!measuring || !good)) begin
      state_d = MEASURE;
      good_d = '0;
    end else if (rise && state_q == MEASURE) begin
      good_d = good_q + 8'd1;
      state_d = good_d == LOCK_N ? LOCKED : MEASURE;
    end else if (!rise && measuring && cnt_q == TMO - 1'b1) begin
      state_d = LOST;
    end
    ms_d = state_d != LOCKED ? '0 : rise && state_q == LOCKED ? (ms_q == MS_LAST ? '0 : ms_q + 1'b1) : ms_q;
    sec_d = rise && state_q == LOCKED && ms_q == MS_LAST;
  end
  // state and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEARCH;
      cnt_q <= '0;
      period_q <= '0;
      good_q <= '0;
      ms_q <= '0;
      sec_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      period_q <= period_d;
      good_q <= good_d;
      ms_q <= ms_d;
      sec_q <= sec_d;
    end
  end
  assign sec_tick = sec_q;
  assign locked = state_q == LOCKED;
  assign lost = state_q == LOST;
  assign period = period_q;
`ifdef CLK_TICK_MONITOR_JITTER_STATS_EN
  logic [PERIOD_W-1:0] period_min_q, period_min_d, period_max_q, period_max_d;
  // seed on lock entry, widen on every rise while locked, hold otherwise
  always_comb begin
    period_min_d = period_min_q;
    period_max_d = period_max_q;
    if (rise && state_q == MEASURE && state_d == LOCKED) begin
      period_min_d = period_new;
      period_max_d = period_new;
    end else if (rise && state_q == LOCKED) begin
      period_min_d = period_new < period_min_q ? period_new : period_min_q;
      period_max_d = period_new > period_max_q ? period_new : period_max_q;
    end
  end
  // jitter statistic registers
  always_ff @(posedge clk) begin
    if (rst) begin
      period_min_q <= '0;
      period_max_q <= '0;
    end else begin
      period_min_q <= period_min_d;
      period_max_q <= period_max_d;
    end
  end
  assign period_min = period_min_q;
  assign period_max = period_max_q;
`else
  assign period_min = '0;
  assign period_max = '0;
`endif
endmodule

// File: doc/clk_tick_monitor.md
Name: clk_tick_monitor

Overview:
- Receiving end of the system clock-divider output.
- Takes the divided 1 kHz square wave `clk_div`, synchronizes it into the 50 MHz `clk` domain and emits single-cycle `tick` enables.
- Measures each period and declares lock or loss of the divided clock.
- Derives a 1 s `sec_tick` for the charge-time countdown logic.

Parameters:
- NUM_DIV, 50000, expected `clk_div` period in `clk` cycles.
- TOL, 64, allowed ±deviation of a measured period from NUM_DIV.
- LOCK_CNT, 4, consecutive in-tolerance periods required to lock.
- TIMEOUT, 100000, `clk` cycles without a rising edge before loss is declared.
- MS_PER_SEC, 1000, ticks per `sec_tick`.

Ports:
- clk  in  1  50 MHz system clock.
- rst  in  1  synchronous, active-high reset.
- clk_div  in  1  divided clock; asynchronous to `clk` sampling.
- tick  out  1  one-cycle pulse per `clk_div` rising edge.
- sec_tick  out  1  one-cycle pulse every MS_PER_SEC ticks while locked.
- locked  out  1  high in LOCKED state.
- lost  out  1  high in LOST state.
- period  out  17  last measured period in `clk` cycles.
- period_min  out  17  minimum period since lock (JITTER_STATS_EN).
- period_max  out  17  maximum period since lock (JITTER_STATS_EN).

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: all outputs 0; FSM in SEARCH; all counters 0; sync flops 0.
- Synchronizer: two flops s1→s2, then an edge flop s3.
  - rise = s2 & ~s3.
  - `tick` is registered rise: high exactly 3 clk edges after the first edge sampling `clk_div`=1.
  - Width exactly 1 cycle.
- Period counter `cnt` (17 b):
  - Increments every cycle and saturates at TIMEOUT.
  - On a rise cycle: `period` <= cnt+1 (only when FSM is not SEARCH), and cnt <= 0.
- good = (period_new ≥ NUM_DIV−TOL) && (period_new ≤ NUM_DIV+TOL), with unsigned compare on 17 b.
- FSM states: SEARCH, MEASURE, LOCKED, LOST.
  - SEARCH: on rise → MEASURE, good_cnt=0; `period` not updated (no valid start).
  - MEASURE, on rise:
    - good → good_cnt++; when good_cnt reaches LOCK_CNT → LOCKED.
    - bad → good_cnt=0, stay in MEASURE.
  - LOCKED: on rise with bad period → MEASURE, good_cnt=0.
  - MEASURE or LOCKED: cnt reaching TIMEOUT → LOST.
  - LOST: on rise → MEASURE, good_cnt=0; this rise only starts a measurement, and `period` is not updated.
- Simultaneous rise and TIMEOUT in the same cycle: the rise wins and is treated as a bad period.
- `sec_tick` ms counter (10 b):
  - Increments on `tick` only while LOCKED.
  - At MS_PER_SEC−1 with `tick`: wraps to 0 and `sec_tick` pulses in the same cycle as `tick`.
  - Cleared on any exit from LOCKED.
- `tick` is emitted in all states, including SEARCH and LOST.
- Reset mid-operation: everything returns to reset values in the following cycle; the sync flops clear, so a `clk_div` level of 1 at reset release produces a `tick` 3 cycles later.

Optional Feature:
- Macro: CLK_TICK_MONITOR_JITTER_STATS_EN.
- Defined:
  - `period_min`/`period_max` load the first measured period on entry to LOCKED.
  - They update on each rise while LOCKED.
  - They hold their values outside LOCKED.
- Undefined: both ports tied to 0 and no registers inferred.

Decomposition:
- Package clk_tick_pkg:
  - FSM state enum (2 b).
  - PERIOD_W=17, MS_W=10.
  - Default constants NUM_DIV/TOL/TIMEOUT.
- One sub-module: sync_edge_det.
  - Contains the 2-flop synchronizer plus the edge flop.
  - Outputs registered rise.
  - Reset to 0.

Test Plan (NUM_DIV=100, TOL=2, LOCK_CNT=4, TIMEOUT=200, MS_PER_SEC=5):
- Steady clean clock, period 100 → `tick` every 100 cycles, 3-cycle latency from the first high sample; `locked`=1 after the 5th rise (4 good periods); `period`=100.
- Locked, 5 further ticks → `sec_tick` coincident with the 5th tick; no `sec_tick` during MEASURE.
- Locked, single period of 105 → `locked` drops on that rise and the ms counter clears; relock after 4 good periods.
- Stop `clk_div` at 0 while locked → `lost`=1 exactly 200 cycles after the last rise; restart → MEASURE on the first rise, `locked` after 4 more good periods.
- Periods alternating 98/102 → stays locked; with the macro defined, `period_min`=98 and `period_max`=102.
- Assert `rst` for 1 cycle while locked → all outputs 0 the next cycle; FSM=SEARCH; `period` stays 0 until the 2nd rise after reset.
